// File: rtl/uart_rx_fifo.sv
// UART receive-side capture FSM feeding a show-ahead byte FIFO, with sticky overflow/framing flags.
// Define UART_RX_ERR_CNT_EN to build the saturating framing-error counter; otherwise err_cnt reads 0.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  rx_err,
    output logic                  rx_clr,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    output logic                  ferr,
    input  logic                  clr_flags,
    output logic [7:0]            err_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   ferr_q, ferr_d;
    logic [7:0]             hold_q, hold_d;
    logic [7:0]             mem [DEPTH];

    logic capture_done;
    logic capture_err;
    logic pop_ok;
    logic push_ok;
    logic ovf_set;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        rx_clr       = 1'b0;
        capture_done = 1'b0;
        capture_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_err) begin
                    capture_err = 1'b1;
                    state_d     = S_CLEAR;
                end else if (rx_done) begin
                    capture_done = 1'b1;
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rx_clr  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Flags must fall before re-arming, otherwise one frame would be taken twice.
                if (!rx_done && !rx_err) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign ferr    = ferr_q;
    // Show-ahead head; when empty the last head byte is held so the bus sees a stable value.
    assign rd_data = empty ? hold_q : mem[rd_ptr_q];

    always_comb begin
        pop_ok  = rd_en && !empty;
        push_ok = capture_done && (!full || pop_ok);
        ovf_set = capture_done && full && !pop_ok;

        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end

        // A new event outranks a simultaneous clear so it is never lost.
        ovf_d  = ovf_set     || (ovf_q  && !clr_flags);
        ferr_d = capture_err || (ferr_q && !clr_flags);
        hold_d = rd_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            hold_q   <= hold_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; count/pointers gate every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_flags) begin
            err_cnt_d = 8'h00;
        end else if (capture_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule
